// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle for pipe_stage_hs.
// master drives the upstream beat and downstream ready; slave is the stage.
interface pipe_stage_hs_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 in_valid;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 out_up_ready;
  logic                 out_valid;
  logic [PAYLOAD_W-1:0] out_data;
  logic                 in_dn_ready;

  modport master (
    output in_valid, in_data, in_dn_ready,
    input  out_up_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dn_ready,
    output out_up_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_hs.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional skid entry, stall hold, flush bubble and starvation counter.
module pipe_stage_hs #(
  parameter int PAYLOAD_W      = 32,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  pipe_stage_hs_if.slave   bus,
  input  logic             in_stall,
  input  logic             in_flush,
  input  logic             in_cnt_clr,
  output logic [CNT_W-1:0] out_bubble_cnt
);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 up_ready;
  logic                 out_valid;
  logic                 accept;
  logic                 drain;

  assign out_valid = main_valid_q & ~in_stall;
  assign accept    = bus.in_valid & up_ready;
  assign drain     = out_valid & bus.in_dn_ready;

  assign bus.out_valid    = out_valid;
  assign bus.out_data     = main_data_q;
  assign bus.out_up_ready = up_ready;
  assign out_bubble_cnt   = cnt_q;

  generate
    if (SKID != 0) begin : g_skid
      logic                 skid_valid_q, skid_valid_d;
      logic [PAYLOAD_W-1:0] skid_data_q, skid_data_d;

      // Ready depends only on flops, stall and reset: no path from dn_ready.
      assign up_ready = in_rst_n & ~skid_valid_q & ~in_stall;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (in_flush) begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          if (CLEAR_ON_FLUSH != 0) begin
            main_data_d = '0;
            skid_data_d = '0;
          end
        end else if (drain) begin
          if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end else begin
            main_valid_d = accept;
            if (accept) main_data_d = bus.in_data;
          end
        end else if (accept) begin
          if (main_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.in_data;
          end else begin
            main_valid_d = 1'b1;
            main_data_d  = bus.in_data;
          end
        end
      end

      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          skid_valid_q <= 1'b0;
          skid_data_q  <= '0;
        end else begin
          skid_valid_q <= skid_valid_d;
          skid_data_q  <= skid_data_d;
        end
      end
    end else begin : g_noskid
      assign up_ready = in_rst_n & (~main_valid_q | bus.in_dn_ready)
                        & ~in_stall;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (in_flush) begin
          main_valid_d = 1'b0;
          if (CLEAR_ON_FLUSH != 0) main_data_d = '0;
        end else if (drain) begin
          main_valid_d = accept;
          if (accept) main_data_d = bus.in_data;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = bus.in_data;
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (in_cnt_clr) begin
      cnt_d = '0;
    end else if (bus.in_dn_ready & ~out_valid & ~in_stall & ~(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
